// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the CPU bridge FSM states.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WRESP  = 3'd2,
    ST_READ_A = 3'd3,
    ST_READ_D = 3'd4,
    ST_DONE   = 3'd5
  } cpu_axil_state_t;

endpackage

// File: rtl/cpu_axil_master.sv
// Byte-wide CPU request port to AXI4-Lite master bridge. Each CPU access
// becomes one single-beat AXI-Lite transaction; the requester sees a one-cycle
// o_ack once the AXI response has come back.
module cpu_axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic              o_ack,
  output logic [7:0]        o_rdata,
  output logic              o_err,
  output logic              M_AXIL_AWVALID,
  input  logic              M_AXIL_AWREADY,
  output logic [ADDR_W-1:0] M_AXIL_AWADDR,
  output logic              M_AXIL_WVALID,
  input  logic              M_AXIL_WREADY,
  output logic [31:0]       M_AXIL_WDATA,
  output logic [3:0]        M_AXIL_WSTRB,
  input  logic              M_AXIL_BVALID,
  output logic              M_AXIL_BREADY,
  input  logic [1:0]        M_AXIL_BRESP,
  output logic              M_AXIL_ARVALID,
  input  logic              M_AXIL_ARREADY,
  output logic [ADDR_W-1:0] M_AXIL_ARADDR,
  input  logic              M_AXIL_RVALID,
  output logic              M_AXIL_RREADY,
  input  logic [31:0]       M_AXIL_RDATA,
  input  logic [1:0]        M_AXIL_RRESP
);

  cpu_axil_state_t   state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [1:0]        lane_q;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic              capture;

  assign aw_hs   = M_AXIL_AWVALID && M_AXIL_AWREADY;
  assign w_hs    = M_AXIL_WVALID  && M_AXIL_WREADY;
  assign ar_hs   = M_AXIL_ARVALID && M_AXIL_ARREADY;
  assign b_hs    = M_AXIL_BVALID  && M_AXIL_BREADY;
  assign r_hs    = M_AXIL_RVALID  && M_AXIL_RREADY;
  assign capture = (state == ST_IDLE) && i_req;

  // Payloads come straight from the capture registers, so they are stable
  // for as long as the corresponding VALID is held.
  assign M_AXIL_AWADDR = {addr_q[ADDR_W-1:2], 2'b00};
  assign M_AXIL_ARADDR = {addr_q[ADDR_W-1:2], 2'b00};
  assign M_AXIL_WDATA  = {4{wdata_q}};
  assign M_AXIL_WSTRB  = 4'b0001 << lane_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode plus the state-decoded READY and ack outputs.
  always_comb begin
    state_nxt     = state;
    M_AXIL_BREADY = 1'b0;
    M_AXIL_RREADY = 1'b0;
    o_ack         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) state_nxt = i_we ? ST_WRITE : ST_READ_A;
      end
      ST_WRITE: begin
        // A handshake in this very cycle counts as done.
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        M_AXIL_BREADY = 1'b1;
        if (M_AXIL_BVALID) state_nxt = ST_DONE;
      end
      ST_READ_A: begin
        if (ar_hs) state_nxt = ST_READ_D;
      end
      ST_READ_D: begin
        M_AXIL_RREADY = 1'b1;
        if (M_AXIL_RVALID) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_ack     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, registered VALIDs with per-channel done flags, and
  // response capture into o_rdata/o_err.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      lane_q         <= '0;
      M_AXIL_AWVALID <= 1'b0;
      M_AXIL_WVALID  <= 1'b0;
      M_AXIL_ARVALID <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      o_rdata        <= '0;
      o_err          <= 1'b0;
    end else begin
      if (capture) begin
        addr_q         <= i_addr;
        wdata_q        <= i_wdata;
        lane_q         <= i_addr[1:0];
        M_AXIL_AWVALID <= i_we;
        M_AXIL_WVALID  <= i_we;
        M_AXIL_ARVALID <= !i_we;
        aw_done        <= 1'b0;
        w_done         <= 1'b0;
      end
      if (aw_hs) begin
        M_AXIL_AWVALID <= 1'b0;
        aw_done        <= 1'b1;
      end
      if (w_hs) begin
        M_AXIL_WVALID <= 1'b0;
        w_done        <= 1'b1;
      end
      if (ar_hs) M_AXIL_ARVALID <= 1'b0;
      if (b_hs) o_err <= (axil_resp_t'(M_AXIL_BRESP) != OKAY);
      if (r_hs) begin
        o_rdata <= M_AXIL_RDATA[{lane_q, 3'b000} +: 8];
        o_err   <= (axil_resp_t'(M_AXIL_RRESP) != OKAY);
      end
    end
  end

endmodule

// File: tb/tb_cpu_axil_master.sv
// Directed bench for cpu_axil_master with a configurable-latency AXI-Lite
// slave model.
module tb_cpu_axil_master;
  import axil_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0, i_we = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [7:0]        i_wdata = '0;
  logic              o_ack, o_err;
  logic [7:0]        o_rdata;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  always #5 clk = ~clk;

  cpu_axil_master #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err),
    .M_AXIL_AWVALID(awvalid), .M_AXIL_AWREADY(awready), .M_AXIL_AWADDR(awaddr),
    .M_AXIL_WVALID(wvalid), .M_AXIL_WREADY(wready), .M_AXIL_WDATA(wdata), .M_AXIL_WSTRB(wstrb),
    .M_AXIL_BVALID(bvalid), .M_AXIL_BREADY(bready), .M_AXIL_BRESP(bresp),
    .M_AXIL_ARVALID(arvalid), .M_AXIL_ARREADY(arready), .M_AXIL_ARADDR(araddr),
    .M_AXIL_RVALID(rvalid), .M_AXIL_RREADY(rready), .M_AXIL_RDATA(rdata), .M_AXIL_RRESP(rresp)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration (written by the stimulus thread only).
  int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;

  // Slave observations (written by the slave thread only).
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, viol = 0;
  int          b_hs_c = 0, r_hs_c = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [11:0] strb_hist = '0;

  // Slave model: drives on the falling edge; a VALID&READY pair seen at the
  // falling edge is the handshake taken on the following rising edge.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, ar_got, b_drop, r_drop, p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [3:0] p_wstrb;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_drop = 0; r_drop = 0;
    p_aw = 0; p_w = 0; p_ar = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_drop = 0; r_drop = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw && (!awvalid || awaddr != p_awaddr)) viol++;
        if (p_w && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) viol++;
        if (p_ar && (!arvalid || araddr != p_araddr)) viol++;
        if (b_drop) begin bvalid = 0; b_drop = 0; end
        if (aw_got && w_got) begin
          if (b_cnt >= b_lat) begin
            bvalid = 1; bresp = s_bresp; aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (bvalid && bready) begin n_b++; b_hs_c = cyc; b_drop = 1; end
        if (r_drop) begin rvalid = 0; r_drop = 0; end
        if (ar_got) begin
          if (r_cnt >= r_lat) begin
            rvalid = 1; rdata = s_rdata; rresp = s_rresp; ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
        if (rvalid && rready) begin n_r++; r_hs_c = cyc; r_drop = 1; end
        awready = awvalid && (aw_cnt >= aw_lat);
        if (awvalid && !awready) aw_cnt++;
        if (awvalid && awready) begin n_aw++; last_awaddr = awaddr; aw_got = 1; aw_cnt = 0; end
        p_aw = awvalid && !awready; p_awaddr = awaddr;
        wready = wvalid && (w_cnt >= w_lat);
        if (wvalid && !wready) w_cnt++;
        if (wvalid && wready) begin
          n_w++; last_wdata = wdata; last_wstrb = wstrb;
          strb_hist = {strb_hist[7:0], wstrb}; w_got = 1; w_cnt = 0;
        end
        p_w = wvalid && !wready; p_wdata = wdata; p_wstrb = wstrb;
        arready = arvalid && (ar_cnt >= ar_lat);
        if (arvalid && !arready) ar_cnt++;
        if (arvalid && arready) begin n_ar++; last_araddr = araddr; ar_got = 1; ar_cnt = 0; end
        p_ar = arvalid && !arready; p_araddr = araddr;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and watch 30 cycles; lat is the ack cycle index where
  // index 0 is the cycle right after capture.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                         input logic drop, output int lat, output int acks, output int ack_c,
                         output logic [7:0] rd, output logic er);
    lat = -1; acks = 0; ack_c = 0; rd = 0; er = 0;
    @(negedge clk);
    i_req = 1; i_we = we; i_addr = addr; i_wdata = wd;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (drop && c == 0) i_req = 0;
      if (o_ack) begin
        acks++;
        if (lat < 0) begin lat = c; ack_c = cyc; rd = o_rdata; er = o_err; end
        i_req = 0;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
    int          aw_l, w_l, b_l, ar_l, r_l;
    logic [31:0] rdat;
    logic [1:0]  resp;
    logic        drop;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [7:0]  e_rdata;
    logic        e_err;
    int          e_lat;
  } vec_t;

  vec_t vecs[8];
  vec_t v;
  int   lat, acks, ack_c, k, found;
  int   s_aw, s_w, s_b, s_ar, s_r, s_v;
  int   ack_cs[3];
  logic [7:0] rd;
  logic er;

  initial begin
    //          we    addr           wd     aw w  b  ar r  rdata          resp   drop  e_addr         strb     e_wdata        e_rd   err  lat
    vecs[0] = '{1'b1, 32'h0000_0006, 8'hA5, 0, 0, 0, 0, 0, 32'h0,         2'b00, 1'b0, 32'h0000_0004, 4'b0100, 32'hA5A5_A5A5, 8'h00, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h0000_0101, 8'h3C, 2, 0, 0, 0, 0, 32'h0,         2'b00, 1'b0, 32'h0000_0100, 4'b0010, 32'h3C3C_3C3C, 8'h00, 1'b0, 4};
    vecs[2] = '{1'b1, 32'h0000_0203, 8'h5A, 0, 2, 0, 0, 0, 32'h0,         2'b00, 1'b1, 32'h0000_0200, 4'b1000, 32'h5A5A_5A5A, 8'h00, 1'b0, 4};
    vecs[3] = '{1'b1, 32'h0000_0008, 8'hFF, 0, 0, 0, 0, 0, 32'h0,         2'b10, 1'b0, 32'h0000_0008, 4'b0001, 32'hFFFF_FFFF, 8'h00, 1'b1, 2};
    vecs[4] = '{1'b0, 32'h0000_0013, 8'h00, 0, 0, 0, 0, 4, 32'h1122_3344, 2'b00, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         8'h11, 1'b0, 6};
    vecs[5] = '{1'b0, 32'h0000_0000, 8'h00, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000, 4'b0000, 32'h0,         8'hEF, 1'b1, 2};
    vecs[6] = '{1'b0, 32'h0000_0002, 8'h00, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         8'hAD, 1'b0, 3};
    vecs[7] = '{1'b0, 32'hFFFF_FFF5, 8'h00, 0, 0, 0, 0, 0, 32'h89AB_CDEF, 2'b11, 1'b0, 32'hFFFF_FFF4, 4'b0000, 32'h0,         8'hCD, 1'b1, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'({awvalid, wvalid, bready, arvalid, rready, o_ack, o_err}), 32'h0);
    chk("reset_rdata", 32'(o_rdata), 32'h0);
    chk("reset_awaddr", awaddr, 32'h0);
    rst = 0;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      aw_lat = v.aw_l; w_lat = v.w_l; b_lat = v.b_l; ar_lat = v.ar_l; r_lat = v.r_l;
      s_rdata = v.rdat; s_bresp = v.resp; s_rresp = v.resp;
      s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r; s_v = viol;
      run_txn(v.we, v.addr, v.wd, v.drop, lat, acks, ack_c, rd, er);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.e_lat));
      chk($sformatf("v%0d_ack_count", i), 32'(acks), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(v.e_err));
      chk($sformatf("v%0d_valid_stable", i), 32'(viol - s_v), 32'd0);
      if (v.we) begin
        chk($sformatf("v%0d_awaddr", i), last_awaddr, v.e_addr);
        chk($sformatf("v%0d_wstrb", i), 32'(last_wstrb), 32'(v.e_strb));
        chk($sformatf("v%0d_wdata", i), last_wdata, v.e_wdata);
        chk($sformatf("v%0d_aw_w_b_ar_counts", i),
            32'({8'(n_aw - s_aw), 8'(n_w - s_w), 8'(n_b - s_b), 8'(n_ar - s_ar)}), 32'h0101_0100);
        chk($sformatf("v%0d_ack_after_b", i), 32'(ack_c), 32'(b_hs_c + 1));
      end else begin
        chk($sformatf("v%0d_araddr", i), last_araddr, v.e_addr);
        chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(v.e_rdata));
        chk($sformatf("v%0d_ar_r_aw_counts", i),
            32'({8'(n_ar - s_ar), 8'(n_r - s_r), 8'(n_aw - s_aw), 8'(n_b - s_b)}), 32'h0101_0000);
        chk($sformatf("v%0d_ack_after_r", i), 32'(ack_c), 32'(r_hs_c + 1));
      end
    end

    // i_req held high across three back-to-back writes
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0; s_bresp = 2'b00;
    s_aw = n_aw; s_b = n_b; acks = 0; k = 0;
    ack_cs[0] = 0; ack_cs[1] = 0; ack_cs[2] = 0;
    @(negedge clk);
    i_req = 1; i_we = 1; i_addr = 32'h0; i_wdata = 8'h11;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_ack) begin
        acks++;
        if (k < 3) begin ack_cs[k] = cyc; k++; end
        if (k < 3) begin i_addr = 32'(k); i_wdata = 8'h11 + 8'(k); end
        else i_req = 0;
      end
    end
    chk("b2b_ack_count", 32'(acks), 32'd3);
    chk("b2b_aw_count", 32'(n_aw - s_aw), 32'd3);
    chk("b2b_b_count", 32'(n_b - s_b), 32'd3);
    chk("b2b_wstrb_seq", 32'(strb_hist), 32'h0000_0124);
    chk("b2b_last_wdata", last_wdata, 32'h1313_1313);
    chk("b2b_ack_gap01", 32'(ack_cs[1] - ack_cs[0]), 32'd4);
    chk("b2b_ack_gap12", 32'(ack_cs[2] - ack_cs[1]), 32'd4);

    // Reset while waiting for the write response
    b_lat = 5; found = 0;
    @(negedge clk);
    i_req = 1; i_we = 1; i_addr = 32'h40; i_wdata = 8'h77;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (bready) found = 1;
    end
    chk("rst_reached_wresp", 32'(found), 32'd1);
    i_req = 0; rst = 1;
    @(negedge clk);
    chk("rst_mid_ctl", 32'({awvalid, wvalid, bready, arvalid, rready, o_ack, o_err}), 32'h0);
    chk("rst_mid_rdata", 32'(o_rdata), 32'h0);
    chk("rst_mid_awaddr", awaddr, 32'h0);
    @(negedge clk);
    rst = 0; b_lat = 0;
    @(negedge clk);
    s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00; s_v = viol;
    run_txn(1'b0, 32'h21, 8'h00, 1'b0, lat, acks, ack_c, rd, er);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_ack_count", 32'(acks), 32'd1);
    chk("post_rst_rdata", 32'(rd), 32'hF0);
    chk("post_rst_err", 32'(er), 32'd0);
    chk("post_rst_araddr", last_araddr, 32'h20);
    chk("post_rst_valid_stable", 32'(viol - s_v), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_axil_master.md
Name: cpu_axil_master

Overview:
- Byte-wide CPU-side request port to AXI4-Lite master (initiator) bridge.
- Converts each 8-bit CPU read/write into one single-beat AXI-Lite transaction.
- Drives the S_AXIL_* slave port of the SD controller shadow-register stage and other AXI-Lite peripherals.
- Holds the requester off, via a level request plus one-cycle ack, until the AXI response returns.

Parameters:
- ADDR_W, 32, width of CPU request address and AXI AWADDR/ARADDR.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_req  in  1  request, level; held with stable i_addr/i_we/i_wdata until o_ack
- i_we  in  1  1 = write, 0 = read
- i_addr  in  ADDR_W  byte address
- i_wdata  in  8  write byte
- o_ack  out  1  one-cycle completion pulse
- o_rdata  out  8  read byte; valid while o_ack=1
- o_err  out  1  valid while o_ack=1; set when response != OKAY
- M_AXIL_AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_W  write address channel
- M_AXIL_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/32/4  write data channel
- M_AXIL_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel
- M_AXIL_ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_W  read address channel
- M_AXIL_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/32/2  read data channel

Behaviour:
- Reset values: all VALID/READY outputs 0, o_ack 0, o_err 0, o_rdata 0x00, FSM in IDLE, address/data registers 0.
- States:
  - IDLE: on i_req=1, capture i_addr, i_we, i_wdata and byte lane lane=i_addr[1:0]. Go to WRITE if i_we=1, else READ_A.
  - WRITE: AWVALID and WVALID asserted from the cycle after capture.
    - Each drops independently on its own handshake, tracked by aw_done and w_done flags.
    - AW and W may complete in either order or the same cycle.
    - Leave for WRESP when both flags are set, counting handshakes in the current cycle.
  - WRESP: BREADY=1. On BVALID: o_err<=(BRESP!=2'b00), go to DONE.
  - READ_A: ARVALID=1 until ARREADY, then READ_D.
  - READ_D: RREADY=1. On RVALID: o_rdata<=RDATA[lane*8+:8], o_err<=(RRESP!=2'b00), go to DONE.
  - DONE: o_ack=1 for exactly one cycle, then IDLE.
- New requests: IDLE samples i_req again on the cycle after DONE. A still-high i_req there is a new request, so back-to-back requests are legal.
- Address and data encoding:
  - AWADDR/ARADDR = {addr[ADDR_W-1:2], 2'b00}.
  - WSTRB = 4'b0001 << lane.
  - WDATA = {4{wdata}}.
  - Writes never assert more than one strobe bit.
- Registered outputs: VALID signals are registered, never combinationally dependent on READY. Once asserted, VALID and its payload hold stable until the handshake.
- Minimum latency with an always-ready slave:
  - Write: capture T0, AW/W handshake T1, B handshake T2, o_ack T3.
  - Read: capture T0, AR handshake T1, R handshake T2, o_ack T3.
- Boundaries:
  - An error response still completes normally; o_rdata takes the returned lane.
  - i_req dropping mid-transaction is ignored; the transaction runs to completion and o_ack still pulses.
  - i_reset mid-transaction returns everything to reset values immediately; the slave side is reset with it.
  - Unexpected BVALID/RVALID outside WRESP/READ_D is not accepted, since its READY is 0.

Decomposition:
- Shared package axil_pkg:
  - typedef axil_resp_t (2-bit): OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state enum cpu_axil_state_t.
- No sub-module; single FSM plus capture registers.

Test Plan:
- Write addr 0x0000_0006, data 0xA5, slave always ready -> AWADDR 0x4, WSTRB 4'b0100, WDATA 0xA5A5A5A5, o_ack 3 cycles after capture, o_err 0.
- Write with WREADY 2 cycles before AWREADY, then reverse order -> each VALID drops only on its own handshake, exactly one B accepted, single o_ack.
- Read addr 0x13, RDATA 0x11223344 after 4-cycle RVALID delay -> ARADDR 0x10, o_rdata 0x11, o_ack coincides with nothing earlier than R handshake +1.
- Read with RRESP SLVERR, RDATA 0xDEADBEEF, addr 0x0 -> o_rdata 0xEF, o_err 1 during o_ack.
- i_req held high over 3 writes to addresses 0,1,2 -> three AXI write transactions, WSTRB 0001/0010/0100, three o_ack pulses.
- i_reset asserted while in WRESP -> next cycle all VALID/READY 0, o_ack 0; subsequent read completes normally.
